// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR bus responders: modify codes, the UART
// receive status word layout, CSR addresses, the receiver FSM state type and
// a helper that assembles the receive status word.
// ---------------------------------------------------------------------------
package csr_pkg;

    // CSR modify codes carried on the modify bus
    localparam logic [2:0] MOD_NONE  = 3'd0;
    localparam logic [2:0] MOD_WRITE = 3'd1;
    localparam logic [2:0] MOD_SET   = 3'd2;
    localparam logic [2:0] MOD_CLEAR = 3'd3;

    // Bit positions inside the receive status word
    localparam int RX_EMPTY_BIT = 31;
    localparam int RX_OVR_BIT   = 9;
    localparam int RX_FERR_BIT  = 8;

    // CSR addresses
    localparam logic [11:0] CSR_UART = 12'hBC0;

    // Receiver FSM states
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // Assemble {empty, 21'b0, ovr, ferr, byte}
    function automatic logic [31:0] rx_status(input logic       empty,
                                              input logic       ovr,
                                              input logic       ferr,
                                              input logic [7:0] data);
        logic [31:0] word;
        word               = 32'h0000_0000;
        word[RX_EMPTY_BIT] = empty;
        word[RX_OVR_BIT]   = ovr;
        word[RX_FERR_BIT]  = ferr;
        word[7:0]          = data;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with 2**DEPTH_LOG2 entries. Read and write pointers carry
// one extra wrap bit so full and empty are distinguished without a counter.
// The head entry is visible combinationally on rdata. A push into a full FIFO
// is accepted only when it coincides with a pop (the popped slot is reused).
//
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset
//   push   write wdata at the tail
//   pop    drop the head entry (ignored when empty)
//   wdata  data to push
//   rdata  head entry
//   full   no free entry
//   empty  no valid entry
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic                do_push_s;
    logic                do_pop_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                   (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
    assign rdata = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];

    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage array and pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= wdata;
                wr_ptr_r <= wr_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/csr_uart_rx.sv
// ---------------------------------------------------------------------------
// csr_uart_rx
// CSR-mapped 8N1 UART receiver. The serial line is synchronised, framed by a
// small FSM and received bytes are queued in a FIFO. A CSR read at BASE_ADDR
// returns {empty, 21'b0, ovr, ferr, byte} one cycle later and pops the head.
// A write/clear modify to BASE_ADDR clears the sticky ferr/ovr flags.
//
// Ports:
//   clk     clock
//   rst     asynchronous active-high reset
//   read    CSR read strobe, qualified by addr
//   modify  CSR modify code, refers to the previous cycle's addr
//   wdata   CSR write data, valid with modify
//   addr    CSR address
//   rdata   read data, zero whenever valid is low
//   valid   this responder claims the access
//   rx      asynchronous serial input, idle high
//   irq     high while the FIFO holds data (registered)
// ---------------------------------------------------------------------------
module csr_uart_rx
    import csr_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = CSR_UART,
    parameter int          DIVISOR    = 868,
    parameter int          DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        irq
);

    localparam int CNT_W = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);

    // Synchroniser
    logic rx_meta_r;
    logic rx_sync_r;

    // Receiver FSM
    rx_state_e        state_r;
    rx_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic             push_s;
    logic             ferr_set_s;

    // FIFO and flags
    logic [7:0] fifo_rdata_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic       pop_s;
    logic       ovr_set_s;
    logic       ferr_r;
    logic       ovr_r;

    // CSR decode
    logic rd_hit_s;
    logic addr_hit_d_r;
    logic clr_hit_s;
    logic unused_s;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receiver FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RX_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            shift_r <= shift_nxt_s;
        end
    end

    // Receiver FSM next state; the start bit is re-checked at its midpoint so
    // that every later sample lands in the middle of a bit period
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        push_s      = 1'b0;
        ferr_set_s  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_nxt_s = '0;
                if (!rx_sync_r) begin
                    state_nxt_s = RX_START;
                end else begin
                    state_nxt_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_nxt_s = '0;
                    idx_nxt_s = 3'd0;
                    if (rx_sync_r) begin
                        state_nxt_s = RX_IDLE;
                    end else begin
                        state_nxt_s = RX_DATA;
                    end
                end else begin
                    state_nxt_s = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_r == CNT_FULL) begin
                    cnt_nxt_s          = '0;
                    shift_nxt_s[idx_r] = rx_sync_r;
                    idx_nxt_s          = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
                        state_nxt_s = RX_STOP;
                    end else begin
                        state_nxt_s = RX_DATA;
                    end
                end else begin
                    state_nxt_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_r == CNT_FULL) begin
                    cnt_nxt_s = '0;
                    if (rx_sync_r) begin
                        push_s      = 1'b1;
                        state_nxt_s = RX_IDLE;
                    end else begin
                        ferr_set_s  = 1'b1;
                        state_nxt_s = RX_BREAK;
                    end
                end else begin
                    state_nxt_s = RX_STOP;
                end
            end
            RX_BREAK: begin
                // Hold off until the line returns high so a break is not
                // mistaken for a stream of start bits
                cnt_nxt_s = '0;
                if (rx_sync_r) begin
                    state_nxt_s = RX_IDLE;
                end else begin
                    state_nxt_s = RX_BREAK;
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                state_nxt_s = RX_IDLE;
            end
        endcase
    end

    // CSR decode: read hits pop a non-empty FIFO; flag clears use the
    // address seen one cycle before modify
    assign rd_hit_s  = read && (addr == BASE_ADDR);
    assign pop_s     = rd_hit_s && !fifo_empty_s;
    assign clr_hit_s = addr_hit_d_r && ((modify == MOD_WRITE) || (modify == MOD_CLEAR));
    assign ovr_set_s = push_s && fifo_full_s && !pop_s;
    assign unused_s  = ^{wdata[31:10], wdata[7:0]};

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (shift_r),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Previous-cycle address match for the modify phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hit_d_r <= 1'b0;
        end else begin
            addr_hit_d_r <= (addr == BASE_ADDR);
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ferr_r <= 1'b0;
            ovr_r  <= 1'b0;
        end else begin
            if (ferr_set_s) begin
                ferr_r <= 1'b1;
            end else if (clr_hit_s && wdata[RX_FERR_BIT]) begin
                ferr_r <= 1'b0;
            end else begin
                ferr_r <= ferr_r;
            end
            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end else if (clr_hit_s && wdata[RX_OVR_BIT]) begin
                ovr_r <= 1'b0;
            end else begin
                ovr_r <= ovr_r;
            end
        end
    end

    // Registered CSR response and interrupt level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            rdata <= 32'h0000_0000;
            irq   <= 1'b0;
        end else begin
            valid <= rd_hit_s;
            if (rd_hit_s) begin
                rdata <= rx_status(fifo_empty_s, ovr_r, ferr_r,
                                   fifo_empty_s ? 8'h00 : fifo_rdata_s);
            end else begin
                rdata <= 32'h0000_0000;
            end
            irq <= !fifo_empty_s;
        end
    end

endmodule

// File: tb/tb_csr_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_csr_uart_rx
// Self-checking bench for csr_uart_rx with DIVISOR=8, DEPTH_LOG2=2. A
// reference model (byte queue plus sticky flags) predicts each CSR read; the
// prediction is queued when the read is issued and compared when the
// response appears.
// ---------------------------------------------------------------------------
module tb_csr_uart_rx;

    localparam int DIV = 8;

    logic        clk;
    logic        rst;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        rx;
    logic        irq;

    int tests_run;
    int tests_failed;

    // Reference model
    logic [7:0]  m_q[$];
    logic        m_ferr;
    logic        m_ovr;
    logic [32:0] exp_q[$];

    csr_uart_rx #(
        .BASE_ADDR  (12'hBC0),
        .DIVISOR    (DIV),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .read   (read),
        .modify (modify),
        .wdata  (wdata),
        .addr   (addr),
        .rdata  (rdata),
        .valid  (valid),
        .rx     (rx),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Predicted response word for a read at the receive address
    function automatic logic [31:0] model_read();
        logic [31:0] w;
        w    = 32'h0000_0000;
        w[9] = m_ovr;
        w[8] = m_ferr;
        if (m_q.size() == 0) begin
            w[31] = 1'b1;
        end else begin
            w[7:0] = m_q.pop_front();
        end
        return w;
    endfunction

    // One CSR read; the expected {valid, rdata} is queued at issue and
    // checked in the response cycle
    task automatic csr_read(input logic [11:0] a, input string name);
        logic [32:0] exp;
        if (a == 12'hBC0) begin
            exp_q.push_back({1'b1, model_read()});
        end else begin
            exp_q.push_back({1'b0, 32'h0000_0000});
        end
        read = 1'b1;
        addr = a;
        @(posedge clk);
        #1;
        read = 1'b0;
        addr = 12'h000;
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (valid !== exp[32]) begin
            tests_failed++;
            $display("FAIL %s valid: got %b expected %b", name, valid, exp[32]);
        end
        tests_run++;
        if (rdata !== exp[31:0]) begin
            tests_failed++;
            $display("FAIL %s rdata: got %h expected %h", name, rdata, exp[31:0]);
        end
        @(posedge clk);
        #1;
    endtask

    // CSR write: address phase then modify phase
    task automatic csr_write(input logic [2:0] code, input logic [31:0] data);
        addr = 12'hBC0;
        step(1);
        addr   = 12'h000;
        modify = code;
        wdata  = data;
        step(1);
        modify = 3'd0;
        wdata  = 32'h0000_0000;
        if (code == 3'd1 || code == 3'd3) begin
            if (data[8]) m_ferr = 1'b0;
            if (data[9]) m_ovr  = 1'b0;
        end
    endtask

    // Transmit one 8N1 frame with the given stop-bit level
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        step(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(DIV);
        end
        rx = stop_bit;
        step(DIV);
        rx = 1'b1;
        if (stop_bit) begin
            if (m_q.size() >= 4) m_ovr = 1'b1;
            else m_q.push_back(b);
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic check_irq(input logic exp, input string name);
        tests_run++;
        if (irq !== exp) begin
            tests_failed++;
            $display("FAIL %s irq: got %b expected %b", name, irq, exp);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (valid !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b rdata=%h irq=%b expected 0/0/0",
                     valid, rdata, irq);
        end
        csr_read(12'hBC0, "reset_read");
        check_irq(1'b0, "reset_irq");
    endtask

    task automatic test_single_byte();
        send_frame(8'h41, 1'b1);
        step(2);
        check_irq(1'b1, "byte_irq_high");
        csr_read(12'hBC0, "byte_41");
        check_irq(1'b0, "byte_irq_low");
        csr_read(12'hBC0, "byte_empty");
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(3 * DIV);
        csr_read(12'hBC0, "glitch");
    endtask

    task automatic test_framing_error();
        send_frame(8'h55, 1'b0);
        step(4);
        csr_read(12'hBC0, "ferr_read");
        csr_write(3'd1, 32'h0000_0100);
        csr_read(12'hBC0, "ferr_cleared");
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) begin
            send_frame(i[7:0], 1'b1);
        end
        step(2);
        for (int i = 0; i < 5; i++) begin
            csr_read(12'hBC0, $sformatf("b2b_%0d", i));
        end
    endtask

    task automatic test_flags_and_addr();
        send_frame(8'h3C, 1'b1);
        step(2);
        csr_read(12'hBC1, "wrong_addr");
        csr_write(3'd2, 32'h0000_0300);
        csr_read(12'hBC0, "set_noeffect");
        csr_write(3'd3, 32'h0000_0200);
        csr_read(12'hBC0, "ovr_cleared");
    endtask

    task automatic test_reset_midframe();
        rx = 1'b0;
        step(12);
        rst = 1'b1;
        rx  = 1'b1;
        step(2);
        rst = 1'b0;
        model_reset();
        step(2);
        send_frame(8'hA5, 1'b1);
        step(2);
        csr_read(12'hBC0, "midframe_a5");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_reset();
        rst    = 1'b1;
        read   = 1'b0;
        modify = 3'd0;
        wdata  = 32'h0000_0000;
        addr   = 12'h000;
        rx     = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);

        test_reset();
        test_single_byte();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_flags_and_addr();
        test_reset_midframe();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
